// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive controller.
// Holds the deserialiser state encoding, parity-mode codes and the minimum baud divider.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [15:0] MIN_BAUD_DIV = 16'd4;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: register-file side read port and status of the UART receiver.
// slave: rd_en_i/clr_err_i in; rdata/rd_valid/rd_err, FIFO status, sticky flags, irq out.
interface uart_rx_ctrl_if #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 5
);
    logic              rd_en_i;
    logic              clr_err_i;
    logic [DATA_W-1:0] rdata_o;
    logic              rd_valid_o;
    logic [1:0]        rd_err_o;
    logic              full_o;
    logic              empty_o;
    logic [FIFO_AW:0]  level_o;
    logic              pe_o;
    logic              fe_o;
    logic              ovr_o;
    logic [7:0]        ovr_cnt_o;
    logic              irq_o;

    modport slave (
        input  rd_en_i, clr_err_i,
        output rdata_o, rd_valid_o, rd_err_o, full_o, empty_o, level_o,
        output pe_o, fe_o, ovr_o, ovr_cnt_o, irq_o
    );

    modport master (
        output rd_en_i, clr_err_i,
        input  rdata_o, rd_valid_o, rd_err_o, full_o, empty_o, level_o,
        input  pe_o, fe_o, ovr_o, ovr_cnt_o, irq_o
    );
endinterface

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 2-FF synchroniser, bit counter and frame FSM; emits {fe, pe, data} with done tick.
// Ports: clk_i/rstn_i, rx_en_i, uart_rx_i, baud_div_i, parity_mode_i, stop2_i -> done_o, data_o, fe_o, pe_o.
// Macro UART_RX_PARITY_EN builds the PARITY state; otherwise frames carry no parity bit.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              rx_en_i,
    input  logic              uart_rx_i,
    input  logic [15:0]       baud_div_i,
    input  logic [1:0]        parity_mode_i,
    input  logic              stop2_i,
    output logic              done_o,
    output logic [DATA_W-1:0] data_o,
    output logic              fe_o,
    output logic              pe_o
);

    rx_state_e         state_q;
    logic              sync1_q, sync2_q;
    logic [15:0]       cnt_q, div_q;
    logic [3:0]        bit_q;
    logic              stop2_q, fe_acc_q, pe_acc_q;
    logic [DATA_W-1:0] shift_q, data_q;
    logic              done_q, fe_q, pe_q;
`ifdef UART_RX_PARITY_EN
    logic              par_en_q, par_odd_q, par_q;
`else
    logic              unused_mode;
    assign unused_mode = ^parity_mode_i;
`endif

    logic line, fall, tick, mid;
    assign line = sync2_q;
    // Falling edge as it moves into the second flop.
    assign fall = sync2_q & ~sync1_q;
    assign tick = (cnt_q == div_q - 16'd1);
    assign mid  = (cnt_q == (div_q >> 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            stop2_q  <= 1'b0;
            fe_acc_q <= 1'b0;
            pe_acc_q <= 1'b0;
            shift_q  <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            fe_q     <= 1'b0;
            pe_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (!rx_en_i) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (fall && baud_div_i >= MIN_BAUD_DIV) begin
                            state_q <= ST_START;
                            // The edge cycle itself is count 0.
                            cnt_q   <= 16'd1;
                            div_q   <= baud_div_i;
                            stop2_q <= stop2_i;
`ifdef UART_RX_PARITY_EN
                            par_en_q  <= (parity_mode_i == PAR_EVEN) ||
                                         (parity_mode_i == PAR_ODD);
                            par_odd_q <= (parity_mode_i == PAR_ODD);
`endif
                        end
                    end
                    ST_START: begin
                        if (mid) begin
                            cnt_q <= '0;
                            bit_q <= '0;
                            state_q <= line ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
                            par_q <= 1'b0;
`endif
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    ST_DATA: begin
                        if (tick) begin
                            cnt_q   <= '0;
                            shift_q <= {line, shift_q[DATA_W-1:1]};
`ifdef UART_RX_PARITY_EN
                            par_q   <= par_q ^ line;
`endif
                            if (bit_q == 4'(DATA_W - 1)) begin
                                bit_q    <= '0;
                                fe_acc_q <= 1'b0;
                                pe_acc_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                                state_q  <= par_en_q ? ST_PARITY : ST_STOP;
`else
                                state_q  <= ST_STOP;
`endif
                            end else begin
                                bit_q <= bit_q + 4'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (tick) begin
                            cnt_q    <= '0;
                            // Even: bit equals data XOR; odd: its inverse.
                            pe_acc_q <= par_q ^ line ^ par_odd_q;
                            state_q  <= ST_STOP;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (tick) begin
                            cnt_q <= '0;
                            if (stop2_q && bit_q == 4'd0) begin
                                bit_q    <= 4'd1;
                                fe_acc_q <= fe_acc_q | ~line;
                            end else begin
                                bit_q   <= '0;
                                state_q <= ST_IDLE;
                                done_q  <= 1'b1;
                                data_q  <= shift_q;
                                fe_q    <= fe_acc_q | ~line;
                                pe_q    <= pe_acc_q;
                            end
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign done_o = done_q;
    assign data_o = data_q;
    assign fe_o   = fe_q;
    assign pe_o   = pe_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver with tagged RX FIFO, read port, sticky errors and level irq.
// Ports: clk_i, rstn_i, rx_en_i, uart_rx_i, baud_div_i, parity_mode_i, stop2_i, thresh_i, bus (slave).
// Macro UART_RX_PARITY_EN enables parity checking and pe_o; otherwise pe_o and rd_err_o[0] are 0.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 5
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             rx_en_i,
    input  logic             uart_rx_i,
    input  logic [15:0]      baud_div_i,
    input  logic [1:0]       parity_mode_i,
    input  logic             stop2_i,
    input  logic [FIFO_AW:0] thresh_i,
    uart_rx_ctrl_if.slave    bus
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int EW    = DATA_W + 2;
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

    logic              d_done, d_fe, d_pe, pe_tag;
    logic [DATA_W-1:0] d_data;

    uart_rx_deser #(.DATA_W(DATA_W)) u_deser (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .rx_en_i       (rx_en_i),
        .uart_rx_i     (uart_rx_i),
        .baud_div_i    (baud_div_i),
        .parity_mode_i (parity_mode_i),
        .stop2_i       (stop2_i),
        .done_o        (d_done),
        .data_o        (d_data),
        .fe_o          (d_fe),
        .pe_o          (d_pe)
    );

`ifdef UART_RX_PARITY_EN
    assign pe_tag = d_pe;
`else
    logic unused_pe;
    assign unused_pe = d_pe;
    assign pe_tag    = 1'b0;
`endif

    logic [EW-1:0]      mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q;
    logic [1:0]         rerr_q;
    logic               rvalid_q, pe_q, fe_q, ovr_q, irq_q;
    logic [7:0]         ovr_cnt_q;
    logic               full, empty, pop, push, ovr_ev, pe_flag;

    assign full   = (cnt_q == FULL_LVL);
    assign empty  = (cnt_q == '0);
    assign pop    = bus.rd_en_i & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push   = d_done & (~full | pop);
    assign ovr_ev = d_done & full & ~pop;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {d_fe, pe_tag, d_data};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            rerr_q    <= '0;
            rvalid_q  <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
            ovr_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rvalid_q <= pop;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                rdata_q  <= mem_q[rd_ptr_q][DATA_W-1:0];
                rerr_q   <= mem_q[rd_ptr_q][EW-1:DATA_W];
            end
            if (bus.clr_err_i) begin
                pe_q      <= 1'b0;
                fe_q      <= 1'b0;
                ovr_q     <= 1'b0;
                ovr_cnt_q <= '0;
            end else begin
                if (push && pe_tag) pe_q <= 1'b1;
                if (push && d_fe)   fe_q <= 1'b1;
                if (ovr_ev) begin
                    ovr_q <= 1'b1;
                    if (ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
                end
            end
            irq_q <= (cnt_q >= thresh_i) | pe_flag | fe_q | ovr_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign pe_flag = pe_q;
`else
    assign pe_flag = 1'b0;
`endif

    assign bus.rdata_o    = rdata_q;
    assign bus.rd_valid_o = rvalid_q;
    assign bus.rd_err_o   = rerr_q;
    assign bus.full_o     = full;
    assign bus.empty_o    = empty;
    assign bus.level_o    = cnt_q;
    assign bus.pe_o       = pe_flag;
    assign bus.fe_o       = fe_q;
    assign bus.ovr_o      = ovr_q;
    assign bus.ovr_cnt_o  = ovr_cnt_q;
    assign bus.irq_o      = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl (DATA_W=8, FIFO_AW=2).
// Frames are built bit by bit from their byte; expected FIFO entries queue up and are popped on rd_valid_o.
module tb_uart_rx_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          rx_en = 1'b0;
    logic          rx = 1'b1;
    logic [15:0]   div = 16'd16;
    logic [1:0]    pmode = 2'b00;
    logic          stop2 = 1'b0;
    logic [AW:0]   thresh = 3'd7;

    uart_rx_ctrl_if #(.DATA_W(DW), .FIFO_AW(AW)) bus ();

    uart_rx_ctrl #(.DATA_W(DW), .FIFO_AW(AW)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .rx_en_i       (rx_en),
        .uart_rx_i     (rx),
        .baud_div_i    (div),
        .parity_mode_i (pmode),
        .stop2_i       (stop2),
        .thresh_i      (thresh),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int inc_cyc = -1;
    int model_lvl = 0;
    int exp_ovr = 0;
    int exp_valid = 0;
    int got_valid = 0;
    bit exp_pe = 1'b0;
    bit exp_fe = 1'b0;
    logic [7:0] last_rdata = 8'h00;
    logic [AW:0] prev_lvl = '0;
    logic [9:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.level_o > prev_lvl) inc_cyc <= cyc;
        prev_lvl <= bus.level_o;
    end

    function automatic bit par_on(input logic [1:0] m);
`ifdef UART_RX_PARITY_EN
        return (m == 2'b01) || (m == 2'b10);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [9:0] e;
        if (rstn && bus.rd_valid_o) begin
            got_valid++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_unexpected: got %0h tag %b, required no pulse",
                         bus.rdata_o, bus.rd_err_o);
            end else begin
                e = exp_q.pop_front();
                last_rdata = e[7:0];
                if ({bus.rd_err_o, bus.rdata_o} !== e) begin
                    fails++;
                    $display("FAIL rd_entry: got %0h tag %b, required %0h tag %b",
                             bus.rdata_o, bus.rd_err_o, e[7:0], e[9:8]);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        bit bits[$];
        bit p, push, pe_e;
        int n;
        p = par_on(pmode);
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (p) bits.push_back((^d) ^ (pmode == 2'b10) ^ bad_par);
        bits.push_back(!bad_stop);
        if (stop2) bits.push_back(1'b1);
        n = bits.size();
        pe_e = p & bad_par;
        push = (model_lvl < DEPTH);
        if (push) begin
            exp_q.push_back({bad_stop, pe_e, d});
            model_lvl++;
            exp_pe |= pe_e;
            exp_fe |= bad_stop;
        end else if (exp_ovr < 255) begin
            exp_ovr++;
        end
        inc_cyc = -1;
        @(posedge clk); #1;
        fall_cyc = cyc;
        foreach (bits[i]) begin
            rx = bits[i];
            repeat (int'(div)) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (push) chk("latency", inc_cyc - fall_cyc, 2 + n * int'(div) - int'(div) / 2 + 1);
    endtask

    task automatic rd1();
        bit expv;
        expv = (model_lvl > 0);
        @(posedge clk); #1;
        bus.rd_en_i = 1'b1;
        @(posedge clk); #1;
        bus.rd_en_i = 1'b0;
        chk("rd_valid", bus.rd_valid_o, expv);
        if (expv) begin
            model_lvl--;
            exp_valid++;
        end else begin
            chk("rdata_hold", bus.rdata_o, last_rdata);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rdn(input int n);
        @(posedge clk); #1;
        bus.rd_en_i = 1'b1;
        repeat (n) begin
            if (model_lvl > 0) begin
                model_lvl--;
                exp_valid++;
            end
            @(posedge clk); #1;
        end
        bus.rd_en_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        @(posedge clk); #1;
        bus.clr_err_i = 1'b1;
        @(posedge clk); #1;
        bus.clr_err_i = 1'b0;
        exp_ovr = 0;
        exp_pe  = 1'b0;
        exp_fe  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.rd_en_i   = 1'b0;
        bus.clr_err_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_rdata", bus.rdata_o, 0);
        chk("rst_valid", bus.rd_valid_o, 0);
        chk("rst_err", bus.rd_err_o, 0);
        chk("rst_full_empty", {bus.full_o, bus.empty_o}, 2'b01);
        chk("rst_level", bus.level_o, 0);
        chk("rst_flags", {bus.pe_o, bus.fe_o, bus.ovr_o}, 0);
        chk("rst_ovr_cnt", bus.ovr_cnt_o, 0);
        chk("rst_irq", bus.irq_o, 0);
        rstn = 1'b1;
        rx_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 8N1 at 16 clocks per bit
        send(8'hA5, 1'b0, 1'b0);
        chk("8n1_level", bus.level_o, 1);
        rd1();
        chk("8n1_empty", bus.empty_o, 1);

        // even parity with a wrong parity bit
        pmode = 2'b01;
        send(8'h03, 1'b1, 1'b0);
        chk("par_pe", bus.pe_o, par_on(2'b01));
        chk("par_irq", bus.irq_o, par_on(2'b01));
        rd1();
        clr();
        chk("par_pe_clr", bus.pe_o, 0);
        chk("par_irq_clr", bus.irq_o, 0);
        pmode = 2'b00;

        // stop bit low
        send(8'h7E, 1'b0, 1'b1);
        chk("fe_flag", bus.fe_o, 1);
        chk("fe_irq", bus.irq_o, 1);
        rd1();
        clr();
        chk("fe_clr", bus.fe_o, 0);

        // overrun on a 4-deep FIFO
        for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0, 1'b0);
        chk("ovr_full", bus.full_o, 1);
        chk("ovr_level", bus.level_o, 4);
        chk("ovr_flag", bus.ovr_o, 1);
        chk("ovr_cnt", bus.ovr_cnt_o, exp_ovr);
        chk("ovr_irq", bus.irq_o, 1);
        rdn(4);
        chk("ovr_drained", bus.empty_o, 1);
        rd1();
        clr();
        chk("ovr_cnt_clr", bus.ovr_cnt_o, 0);

        // short glitch is a false start
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("glitch_level", bus.level_o, 0);

        // enable dropped mid-frame
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rx_en = 1'b0;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rx_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_level", bus.level_o, 0);
        send(8'h3C, 1'b0, 1'b0);
        chk("abort_next", bus.level_o, 1);
        rd1();

        // level threshold interrupt
        thresh = 3'd2;
        send(8'h11, 1'b0, 1'b0);
        chk("thr_irq_1", bus.irq_o, 0);
        send(8'h22, 1'b0, 1'b0);
        chk("thr_irq_2", bus.irq_o, 1);
        rd1();
        chk("thr_irq_rd", bus.irq_o, 0);
        thresh = 3'd7;
        rd1();

        // randomized frames and reads
        for (int i = 0; i < 24; i++) begin
            div   = 16'(2 * $urandom_range(2, 12));
            stop2 = 1'($urandom);
            pmode = 2'($urandom);
            send(8'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
            if ($urandom_range(0, 1) == 1) rd1();
        end
        chk("rnd_ovr_cnt", bus.ovr_cnt_o, exp_ovr);
        chk("rnd_pe", bus.pe_o, exp_pe);
        chk("rnd_fe", bus.fe_o, exp_fe);
        rdn(model_lvl + 1);
        chk("end_empty", bus.empty_o, 1);
        chk("end_rdata_hold", bus.rdata_o, last_rdata);
        chk("end_queue", exp_q.size(), 0);
        chk("end_valid_cnt", got_valid, exp_valid);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Parametrised second-generation UART receive controller: 2-FF input synchroniser, mid-bit-sampling deserialiser with runtime-selectable parity and stop bits, a tagged receive FIFO, and a bus-side read port with sticky error status and level interrupt. It sits between the `uart_rx_i` pin and the peripheral register file, replacing the fixed 8N1 receive path.

## Interface
- `DATA_W`, 8: data bits per frame, legal 5..8.
- `FIFO_AW`, 5: FIFO address bits; depth is 2**FIFO_AW.
- `clk_i`  in  1  system clock.
- `rstn_i`  in  1  asynchronous, active-low reset.
- `rx_en_i`  in  1  receiver enable; low holds the deserialiser in IDLE.
- `uart_rx_i`  in  1  asynchronous serial input, idle high.
- `baud_div_i`  in  16  clk_i cycles per bit. Values below 4 are reserved and hold the receiver idle.
- `parity_mode_i`  in  2  00 none, 01 even, 10 odd, 11 reserved (treated as none).
- `stop2_i`  in  1  1: two stop bits checked.
- `thresh_i`  in  FIFO_AW+1  level threshold for the interrupt.
- `rd_en_i`  in  1  read request pulse from the register file.
- `clr_err_i`  in  1  clears the sticky error flags and the overrun count.
- `rdata_o`  out  DATA_W  read data.
- `rd_valid_o`  out  1  one-cycle pulse; `rdata_o` and `rd_err_o` are valid.
- `rd_err_o`  out  2  {framing, parity} tag of the entry read.
- `full_o`, `empty_o`  out  1  FIFO status.
- `level_o`  out  FIFO_AW+1  FIFO occupancy.
- `pe_o`, `fe_o`, `ovr_o`  out  1  sticky parity, framing, and overrun flags.
- `ovr_cnt_o`  out  8  overrun count, saturating at 255.
- `irq_o`  out  1  `level_o >= thresh_i` OR `pe_o` OR `fe_o` OR `ovr_o`. Registered.

## Operation
- Reset values:
  - All outputs 0, except `empty_o` = 1.
  - Synchroniser flops = 1.
  - Deserialiser in IDLE.
- Deserialiser states:
  - IDLE: on a synchronised falling edge, go to START.
  - START: at count `baud_div_i>>1`, re-sample. If the line is high, this is a false start; return to IDLE with no write. If low, go to DATA.
  - DATA: sample every `baud_div_i` cycles, LSB first, for `DATA_W` bits, then go to PARITY or STOP.
  - PARITY: sample one bit and compare it against the XOR of the data bits.
  - STOP: sample one stop bit (two if `stop2_i`). Any low sample sets the frame's FE tag. Return to IDLE.
- Bit counter is 16 bits and counts 0..`baud_div_i`-1. Configuration inputs are latched at START and are stable for the rest of the frame.
- Frame write: one cycle after the last stop sample, push {fe, pe, data} (width DATA_W+2) into the FIFO.
  - PE and FE also set the corresponding sticky flags.
  - Error frames are still stored.
- Overrun: a frame completes while the FIFO is full and no read occurs in that cycle.
  - The frame is discarded.
  - `ovr_o` is set and `ovr_cnt_o` increments, saturating at 255.
- Read handshake:
  - `rd_en_i` with `!empty_o` pops the FIFO.
  - The next cycle drives `rdata_o` and `rd_err_o`, and pulses `rd_valid_o`.
  - `rdata_o` holds until the next read.
  - `rd_en_i` while empty is ignored: no pulse, `rdata_o` unchanged.
  - Back-to-back `rd_en_i` is accepted every cycle.
- Simultaneous push and pop:
  - When full, both are accepted and the level is unchanged.
  - When empty, only the push occurs and the pop is ignored.
- `rx_en_i` deasserted mid-frame: abort to IDLE with no write. FIFO contents are kept.
- `clr_err_i` has priority over a set of the sticky flags in the same cycle.

## Timing
- Pin to synchronised line: 2 cycles.
- Falling edge to frame write: 2 + (1 + DATA_W + P + S)·`baud_div_i` − `baud_div_i`/2 + 1 cycles, where P ∈ {0,1} and S ∈ {1,2}.
- `rd_en_i` to `rd_valid_o`: 1 cycle.
- `level_o`, `full_o`, and `empty_o` update in the cycle after the push or pop.
- `irq_o` follows its sources with one further cycle of latency.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state, parity checking, and `pe_o` are implemented.
- Not defined:
  - `parity_mode_i` is ignored and frames are always received without parity.
  - `pe_o` and `rd_err_o[0]` are tied to 0.

## Structure
- Package `uart_pkg` holds:
  - The deserialiser state encoding.
  - Parity-mode constants.
  - The minimum `baud_div` constant.
- Sub-module `uart_rx_deser` contains the synchroniser, bit counter, state machine, and the frame plus tag output with a done tick.
- The FIFO and the read/status logic live in `uart_rx_ctrl`.

## Test plan
- 8N1 at `baud_div_i`=16: send 0xA5, pulse `rd_en_i` → `rd_valid_o` one cycle later with `rdata_o`=0xA5, `rd_err_o`=00, and `empty_o` returns to 1.
- Even parity: send 0x03 with a wrong parity bit → entry tag 01, `pe_o`=1, `irq_o`=1; `clr_err_i` clears it.
- Stop bit forced low on 0x7E → tag 10, `fe_o`=1, data 0x7E still stored.
- FIFO_AW=2: send 5 frames without reading → `full_o`=1, `ovr_cnt_o`=1, and the first 4 bytes read back in order.
- 3-cycle low glitch on an idle line at `baud_div_i`=16 → no write; `rx_en_i` dropped mid-frame → no write, next frame received correctly.
- `thresh_i`=2: after 2 frames `irq_o`=1; one read → `irq_o`=0.
